serial_frame_rx: RTL and testbench

- Downstream consumer of the serial bitstream produced on the slow-clock side (the `data_o` serializer output).
- Hunts for a frame sync pattern, locks alignment and deserializes fixed-width words.
- Delivers words through a 2-entry buffer with valid/ready handshake.
- Reports lock status, sync misses and buffer overruns. Single clock domain (`clk_i`).

---
 rtl/serial_frame_rx.sv | 214 +++++++++++++++++++++
 tb/tb_serial_frame_rx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_frame_rx : sync-hunting serial deserializer, 2-entry word buffer.   |
// | Optional feature macro: SERIAL_FRAME_RX_PARITY_EN (even parity per word).  |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module serial_frame_rx #(
  parameter int                  WIDTH           = 8,
  parameter int                  SYNC_LEN        = 8,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN    = 8'hA5,
  parameter int                  WORDS_PER_FRAME = 4,
  parameter int                  MISS_MAX        = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             data_i,
  input  logic             en_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] word_o,
  output logic             valid_o,
  output logic             locked_o,
  output logic             sync_err_o,
  output logic             overrun_o,
  output logic             par_err_o
);

  localparam int MAXB = (WIDTH > SYNC_LEN) ? WIDTH : SYNC_LEN;
  localparam int BCW  = $clog2(MAXB);
  localparam int HCW  = $clog2(SYNC_LEN);
  localparam int WCW  = $clog2(WORDS_PER_FRAME + 1);
  localparam int MCW  = $clog2(MISS_MAX + 1);

  localparam logic [BCW-1:0] WORD_LAST  = BCW'(WIDTH - 1);
  localparam logic [BCW-1:0] SYNC_LAST  = BCW'(SYNC_LEN - 1);
  localparam logic [HCW-1:0] HUNT_FULL  = HCW'(SYNC_LEN - 1);
  localparam logic [WCW-1:0] FRAME_LAST = WCW'(WORDS_PER_FRAME - 1);
  localparam logic [MCW-1:0] MISS_LAST  = MCW'(MISS_MAX - 1);

  typedef enum logic [1:0] {
    S_HUNT  = 2'd0,
    S_DATA  = 2'd1,
    S_CHECK = 2'd2
  } state_e;

  state_e              state_q;
  logic [SYNC_LEN-2:0] win_q;
  logic [WIDTH-2:0]    word_q;
  logic [HCW-1:0]      hunt_cnt_q;
  logic [BCW-1:0]      bit_cnt_q;
  logic [WCW-1:0]      word_cnt_q;
  logic [MCW-1:0]      miss_cnt_q;
  logic                locked_q;
  logic                sync_err_q;
  logic                overrun_q;

  logic [WIDTH-1:0]    mem_q [0:1];
  logic                rd_ptr_q;
  logic [1:0]          cnt_q;

  logic [SYNC_LEN-1:0] w_win_full;
  logic [WIDTH-1:0]    w_word_full;
  logic                w_sync_hit;
  logic                w_word_done;
  logic                w_push;
  logic [WIDTH-1:0]    w_push_data;
  logic                w_pop;
  logic                w_full;
  logic                w_push_ok;
  logic                w_wr_ptr;

  // The window and word register hold only the prior bits; the current bit
  // is appended combinationally so a match or word completes on its own edge.
  assign w_win_full  = {win_q, data_i};
  assign w_word_full = {word_q, data_i};
  assign w_sync_hit  = (w_win_full == SYNC_PATTERN);

`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic [WIDTH-1:0] hold_q;
  logic             par_phase_q;
  logic             par_err_q;

  assign w_word_done = en_i && (state_q == S_DATA) && par_phase_q;
  assign w_push      = w_word_done && !(^hold_q ^ data_i);
  assign w_push_data = hold_q;
  assign par_err_o   = par_err_q;
`else
  assign w_word_done = en_i && (state_q == S_DATA) && (bit_cnt_q == WORD_LAST);
  assign w_push      = w_word_done;
  assign w_push_data = w_word_full;
  assign par_err_o   = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_HUNT;
      win_q      <= '0;
      word_q     <= '0;
      hunt_cnt_q <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      miss_cnt_q <= '0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      hold_q      <= '0;
      par_phase_q <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      sync_err_q <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      par_err_q  <= 1'b0;
`endif
      if (en_i) begin
        win_q <= w_win_full[SYNC_LEN-2:0];
        unique case (state_q)
          S_HUNT: begin
            if (hunt_cnt_q != HUNT_FULL) hunt_cnt_q <= hunt_cnt_q + 1'b1;
            if ((hunt_cnt_q == HUNT_FULL) && w_sync_hit) begin
              state_q    <= S_DATA;
              locked_q   <= 1'b1;
              bit_cnt_q  <= '0;
              word_cnt_q <= '0;
              miss_cnt_q <= '0;
            end
          end
          S_DATA: begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            if (par_phase_q) begin
              par_phase_q <= 1'b0;
              if (^hold_q ^ data_i) par_err_q <= 1'b1;
            end else begin
              word_q <= w_word_full[WIDTH-2:0];
              if (bit_cnt_q == WORD_LAST) begin
                hold_q      <= w_word_full;
                par_phase_q <= 1'b1;
                bit_cnt_q   <= '0;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
`else
            word_q <= w_word_full[WIDTH-2:0];
            if (bit_cnt_q == WORD_LAST) bit_cnt_q <= '0;
            else                        bit_cnt_q <= bit_cnt_q + 1'b1;
`endif
            if (w_word_done) begin
              if (word_cnt_q == FRAME_LAST) begin
                word_cnt_q <= '0;
                state_q    <= S_CHECK;
              end else begin
                word_cnt_q <= word_cnt_q + 1'b1;
              end
            end
          end
          S_CHECK: begin
            if (bit_cnt_q == SYNC_LAST) begin
              bit_cnt_q <= '0;
              if (w_sync_hit) begin
                miss_cnt_q <= '0;
                state_q    <= S_DATA;
              end else begin
                sync_err_q <= 1'b1;
                if (miss_cnt_q == MISS_LAST) begin
                  state_q    <= S_HUNT;
                  locked_q   <= 1'b0;
                  hunt_cnt_q <= '0;
                  miss_cnt_q <= '0;
                end else begin
                  // Flywheel: keep alignment through an isolated bad sync.
                  miss_cnt_q <= miss_cnt_q + 1'b1;
                  state_q    <= S_DATA;
                end
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          default: state_q <= S_HUNT;
        endcase
      end
    end
  end

  // With two entries the write slot is the head when full, so a simultaneous
  // push and pop overwrites exactly the entry being released.
  assign w_pop     = (cnt_q != 2'd0) && ready_i;
  assign w_full    = cnt_q[1];
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_wr_ptr  = rd_ptr_q ^ cnt_q[0];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      overrun_q <= 1'b0;
    end else begin
      if (w_push_ok) mem_q[w_wr_ptr] <= w_push_data;
      rd_ptr_q  <= rd_ptr_q ^ w_pop;
      cnt_q     <= cnt_q + {1'b0, w_push_ok} - {1'b0, w_pop};
      overrun_q <= w_push && !w_push_ok;
    end
  end

  assign word_o     = mem_q[rd_ptr_q];
  assign valid_o    = (cnt_q != 2'd0);
  assign locked_o   = locked_q;
  assign sync_err_o = sync_err_q;
  assign overrun_o  = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_serial_frame_rx : directed self-checking bench for serial_frame_rx.     |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_serial_frame_rx;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       data_i = 1'b0;
  logic       en_i = 1'b0;
  logic       ready_i = 1'b0;
  logic [7:0] word_o;
  logic       valid_o;
  logic       locked_o;
  logic       sync_err_o;
  logic       overrun_o;
  logic       par_err_o;

  int checks = 0;
  int failures = 0;

  logic [7:0] got[$];
  int n_sync_err = 0;
  int n_overrun  = 0;
  int n_par_err  = 0;

  serial_frame_rx dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .en_i       (en_i),
    .ready_i    (ready_i),
    .word_o     (word_o),
    .valid_o    (valid_o),
    .locked_o   (locked_o),
    .sync_err_o (sync_err_o),
    .overrun_o  (overrun_o),
    .par_err_o  (par_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change 2 time units after a rising edge, so the falling edge sees
  // exactly what the next rising edge will act on.
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (valid_o && ready_i) got.push_back(word_o);
      if (sync_err_o) n_sync_err++;
      if (overrun_o)  n_overrun++;
      if (par_err_o)  n_par_err++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    data_i = b;
    en_i   = 1'b1;
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle(input int n);
    en_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      data_i = 1'($urandom);
      @(posedge clk_i);
      #2;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_word(input logic [7:0] v);
    send_byte(v);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    send_bit(^v);
`endif
  endtask

  task automatic send_bit_gap(input logic b);
    send_bit(b);
    idle(1);
  endtask

  task automatic send_byte_gap(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit_gap(v[i]);
  endtask

  task automatic chk_got(input string tag, input int base, input logic [7:0] exp[$]);
    chk({tag, "_count"}, 32'(got.size() - base), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (base + i < got.size()) chk(tag, 32'(got[base + i]), 32'(exp[i]));
    end
  endtask

  initial begin
    int base;
    int se0;
    int ov0;
    logic [7:0] a5;
    a5 = 8'hA5;

    // Reset state
    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_valid",  32'(valid_o),    0);
    chk("rst_locked", 32'(locked_o),   0);
    chk("rst_word",   32'(word_o),     0);
    chk("rst_serr",   32'(sync_err_o), 0);
    chk("rst_ovr",    32'(overrun_o),  0);
    chk("rst_perr",   32'(par_err_o),  0);
    rst_i = 1'b1;
    idle(2);

    // 1: lock and stream one full frame
    ready_i = 1'b1;
    base = got.size();
    se0  = n_sync_err;
    for (int i = 7; i >= 1; i--) send_bit(a5[i]);
    chk("t1_locked_early", 32'(locked_o), 0);
    send_bit(a5[0]);
    chk("t1_locked", 32'(locked_o), 1);
    send_word(8'h12);
    chk("t1_valid_first", 32'(valid_o), 1);
    chk("t1_word_first",  32'(word_o), 'h12);
    send_word(8'h34);
    send_word(8'h56);
    send_word(8'h78);
    send_byte(8'hA5);
    idle(2);
    chk_got("t1_words", base, '{8'h12, 8'h34, 8'h56, 8'h78});
    chk("t1_serr", 32'(n_sync_err - se0), 0);
    chk("t1_locked_after", 32'(locked_o), 1);

    // 2: back-pressure and overrun
    ready_i = 1'b0;
    base = got.size();
    ov0  = n_overrun;
    send_word(8'h12);
    send_word(8'h34);
    send_word(8'h56);
    chk("t2_ovr_pulse", 32'(overrun_o), 1);
    chk("t2_head",      32'(word_o), 'h12);
    ready_i = 1'b1;
    idle(3);
    chk("t2_valid_drain", 32'(valid_o), 0);
    chk("t2_ovr_count", 32'(n_overrun - ov0), 1);
    send_word(8'h78);
    send_byte(8'hA5);
    idle(2);
    chk_got("t2_words", base, '{8'h12, 8'h34, 8'h78});

    // 3: flywheel on a single bad sync, unlock on two in a row
    base = got.size();
    se0  = n_sync_err;
    send_word(8'h01); send_word(8'h02); send_word(8'h03); send_word(8'h04);
    send_byte(8'hA4);
    chk("t3_serr_pulse", 32'(sync_err_o), 1);
    chk("t3_locked_fly", 32'(locked_o), 1);
    send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
    send_byte(8'hA5);
    send_word(8'h55); send_word(8'h66); send_word(8'h77); send_word(8'h88);
    send_byte(8'hA4);
    chk("t3_locked_one_miss", 32'(locked_o), 1);
    send_word(8'h99); send_word(8'hAA); send_word(8'hBB); send_word(8'hCC);
    send_byte(8'hA4);
    chk("t3_unlocked", 32'(locked_o), 0);
    idle(2);
    chk("t3_serr_count", 32'(n_sync_err - se0), 3);
    chk_got("t3_words", base, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44,
                               8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC});

    // 4: re-acquire after noise bits
    base = got.size();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    for (int i = 7; i >= 1; i--) send_bit(a5[i]);
    chk("t4_locked_early", 32'(locked_o), 0);
    send_bit(a5[0]);
    chk("t4_locked", 32'(locked_o), 1);
    send_word(8'hDE);
    chk("t4_word_first", 32'(word_o), 'hDE);
    send_word(8'hAD); send_word(8'hBE); send_word(8'hEF);
    send_byte(8'hA5);
    idle(2);
    chk_got("t4_words", base, '{8'hDE, 8'hAD, 8'hBE, 8'hEF});

    // 5: gated strobe, then reset mid-word
    rst_i = 1'b0;
    @(posedge clk_i);
    #2;
    rst_i   = 1'b1;
    ready_i = 1'b0;
    base = got.size();
    send_byte_gap(8'hA5);
    chk("t5_locked", 32'(locked_o), 1);
    send_byte_gap(8'hC3);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    send_bit_gap(1'b0);
`endif
    chk("t5_valid", 32'(valid_o), 1);
    chk("t5_word",  32'(word_o), 'hC3);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    #1;
    rst_i = 1'b0;
    #1;
    chk("t5_rst_valid",  32'(valid_o), 0);
    chk("t5_rst_locked", 32'(locked_o), 0);
    chk("t5_rst_word",   32'(word_o), 0);
    idle(1);
    rst_i   = 1'b1;
    ready_i = 1'b1;
    send_byte(8'hA5);
    send_word(8'hC3);
    idle(3);
    chk_got("t5_words", base, '{8'hC3});
    chk("t5_valid_end", 32'(valid_o), 0);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    // 6: parity check drops a word with a bad parity bit
    rst_i = 1'b0;
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    base = got.size();
    send_byte(8'hA5);
    send_byte(8'h12); send_bit(1'b0);
    send_byte(8'h34); send_bit(1'b0);
    chk("t6_perr_pulse", 32'(par_err_o), 1);
    idle(3);
    chk("t6_perr_count", 32'(n_par_err), 1);
    chk_got("t6_words", base, '{8'h12});
`else
    chk("par_err_tied", 32'(n_par_err), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
